// File: rtl/l2_noc_pkg.sv
// Shared NoC decode definitions: header bit positions, decoded header record, decoder FSM states.
package l2_noc_pkg;

  localparam int unsigned FLIT_W    = 64;
  localparam int unsigned MSG_LEN_W = 8;
  localparam int unsigned CHIPID_W  = 14;
  localparam int unsigned COORD_W   = 8;
  localparam int unsigned TYPE_W    = 8;
  localparam int unsigned MSHRID_W  = 8;

  localparam int unsigned HDR_CHIPID_LSB = 50;
  localparam int unsigned HDR_X_LSB      = 42;
  localparam int unsigned HDR_Y_LSB      = 34;
  localparam int unsigned HDR_FBITS_LSB  = 30;
  localparam int unsigned HDR_LEN_LSB    = 22;
  localparam int unsigned HDR_TYPE_LSB   = 14;
  localparam int unsigned HDR_MSHRID_LSB = 6;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_HOLD    = 2'd2
  } dec_state_e;

  // Header fields the decoder keeps with a message
  typedef struct packed {
    logic [MSG_LEN_W-1:0] len;
    logic [TYPE_W-1:0]    mtype;
    logic [MSHRID_W-1:0]  mshrid;
  } noc_hdr_t;

endpackage

// File: rtl/l2_noc2_msg_decoder_if.sv
// NoC2 flit input handshake plus the reassembled message output bundle.
interface l2_noc2_msg_decoder_if #(
  parameter int unsigned MAX_DATA = 2,
  parameter int unsigned CNT_W    = 16
);
  logic                   noc2_valid_in;
  logic [63:0]            noc2_data_in;
  logic                   noc2_ready_out;
  logic                   msg_valid;
  logic                   msg_ready;
  logic [7:0]             msg_type;
  logic [7:0]             msg_mshrid;
  logic [7:0]             msg_len;
  logic [64*MAX_DATA-1:0] msg_data;
  logic                   msg_misroute;
  logic                   msg_trunc;
  logic [CNT_W-1:0]       msg_count;

  modport slave (
    input  noc2_valid_in, noc2_data_in, msg_ready,
    output noc2_ready_out, msg_valid, msg_type, msg_mshrid, msg_len,
           msg_data, msg_misroute, msg_trunc, msg_count
  );

  modport master (
    output noc2_valid_in, noc2_data_in, msg_ready,
    input  noc2_ready_out, msg_valid, msg_type, msg_mshrid, msg_len,
           msg_data, msg_misroute, msg_trunc, msg_count
  );
endinterface

// File: rtl/l2_noc_hdr_unpack.sv
// Combinational NoC header field extraction and destination (misroute) compare.
module l2_noc_hdr_unpack
  import l2_noc_pkg::*;
(
  input  logic [FLIT_W-1:0]   flit,
  input  logic [CHIPID_W-1:0] own_chipid,
  input  logic [COORD_W-1:0]  own_x,
  input  logic [COORD_W-1:0]  own_y,
  output noc_hdr_t            hdr_c,
  output logic                misroute_c
);

  logic [CHIPID_W-1:0] dst_chipid;
  logic [COORD_W-1:0]  dst_x;
  logic [COORD_W-1:0]  dst_y;
  logic                unused_bits;

  assign dst_chipid = flit[HDR_CHIPID_LSB +: CHIPID_W];
  assign dst_x      = flit[HDR_X_LSB +: COORD_W];
  assign dst_y      = flit[HDR_Y_LSB +: COORD_W];

  assign hdr_c.len    = flit[HDR_LEN_LSB +: MSG_LEN_W];
  assign hdr_c.mtype  = flit[HDR_TYPE_LSB +: TYPE_W];
  assign hdr_c.mshrid = flit[HDR_MSHRID_LSB +: MSHRID_W];

  assign misroute_c = (dst_chipid != own_chipid) || (dst_x != own_x) || (dst_y != own_y);

  // fbits and opt carry nothing this decoder needs
  assign unused_bits = ^{flit[HDR_FBITS_LSB +: 4], flit[HDR_MSHRID_LSB-1:0]};

endmodule

// File: rtl/l2_noc2_msg_decoder.sv
// Reassembles L2 NoC2 response flit trains into one held message record with consumer handshake.
module l2_noc2_msg_decoder
  import l2_noc_pkg::*;
#(
  parameter int unsigned MAX_DATA = 2,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHIPID_W-1:0] chipid,
  input  logic [COORD_W-1:0]  coreid_x,
  input  logic [COORD_W-1:0]  coreid_y,
  l2_noc2_msg_decoder_if.slave bus
);

  dec_state_e state_q, state_nx;
  logic       hdr_acc, data_acc, msg_acc;
  noc_hdr_t   hdr_c;
  logic       misroute_c;

  logic [TYPE_W-1:0]    type_q;
  logic [MSHRID_W-1:0]  mshrid_q;
  logic [MSG_LEN_W-1:0] len_q;
  logic [MSG_LEN_W-1:0] rem_q;
  logic [MSG_LEN_W-1:0] idx_q;
  logic                 misroute_q;
  logic                 trunc_q;
  logic [CNT_W-1:0]     count_q;
  logic [MAX_DATA-1:0]  slot_we;
  logic [MAX_DATA-1:0][FLIT_W-1:0] data_q;

  l2_noc_hdr_unpack u_hdr_unpack (
    .flit       (bus.noc2_data_in),
    .own_chipid (chipid),
    .own_x      (coreid_x),
    .own_y      (coreid_y),
    .hdr_c      (hdr_c),
    .misroute_c (misroute_c)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_nx;
  end

  // Next state and handshake strobes
  always_comb begin
    state_nx = state_q;
    hdr_acc  = 1'b0;
    data_acc = 1'b0;
    msg_acc  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.noc2_valid_in) begin
          hdr_acc  = 1'b1;
          state_nx = (hdr_c.len == '0) ? ST_HOLD : ST_PAYLOAD;
        end
      end
      ST_PAYLOAD: begin
        if (bus.noc2_valid_in) begin
          data_acc = 1'b1;
          if (rem_q == MSG_LEN_W'(1)) state_nx = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (bus.msg_ready) begin
          msg_acc  = 1'b1;
          state_nx = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Header latch, payload bookkeeping and accepted-message counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      type_q     <= '0;
      mshrid_q   <= '0;
      len_q      <= '0;
      rem_q      <= '0;
      idx_q      <= '0;
      misroute_q <= 1'b0;
      trunc_q    <= 1'b0;
      count_q    <= '0;
    end else begin
      if (hdr_acc) begin
        type_q     <= hdr_c.mtype;
        mshrid_q   <= hdr_c.mshrid;
        len_q      <= hdr_c.len;
        rem_q      <= hdr_c.len;
        idx_q      <= '0;
        misroute_q <= misroute_c;
        trunc_q    <= hdr_c.len > MSG_LEN_W'(MAX_DATA);
      end
      if (data_acc) begin
        idx_q <= idx_q + MSG_LEN_W'(1);
        rem_q <= rem_q - MSG_LEN_W'(1);
      end
      if (msg_acc) count_q <= count_q + CNT_W'(1);
    end
  end

  // Flits past MAX_DATA match no slot and are dropped
  always_comb begin
    for (int i = 0; i < MAX_DATA; i++) begin
      slot_we[i] = data_acc && (idx_q == MSG_LEN_W'(i));
    end
  end

  // Payload store, cleared by each new header
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
    end else if (hdr_acc) begin
      data_q <= '0;
    end else begin
      for (int i = 0; i < MAX_DATA; i++) begin
        if (slot_we[i]) data_q[i] <= bus.noc2_data_in;
      end
    end
  end

  assign bus.noc2_ready_out = rst_n && (state_q != ST_HOLD);
  assign bus.msg_valid      = (state_q == ST_HOLD);
  assign bus.msg_type       = type_q;
  assign bus.msg_mshrid     = mshrid_q;
  assign bus.msg_len        = len_q;
  assign bus.msg_data       = data_q;
  assign bus.msg_misroute   = misroute_q;
  assign bus.msg_trunc      = trunc_q;
  assign bus.msg_count      = count_q;

endmodule

// File: tb/tb_l2_noc2_msg_decoder.sv
// Bench for l2_noc2_msg_decoder: directed and random flit trains against a message-level model.
module tb_l2_noc2_msg_decoder;

  localparam int unsigned MAX_DATA = 2;
  localparam int unsigned CNT_W    = 12;
  localparam int unsigned DW       = 64 * MAX_DATA;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic [13:0] chipid;
  logic [7:0]  coreid_x;
  logic [7:0]  coreid_y;

  int errors = 0;
  int checks = 0;
  int model_count = 0;

  l2_noc2_msg_decoder_if #(.MAX_DATA(MAX_DATA), .CNT_W(CNT_W)) bus ();

  l2_noc2_msg_decoder #(.MAX_DATA(MAX_DATA), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .chipid   (chipid),
    .coreid_x (coreid_x),
    .coreid_y (coreid_y),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one flit and wait (bounded) for it to be taken
  task automatic send_flit(input logic [63:0] f, output int waited);
    waited = 0;
    bus.noc2_valid_in = 1'b1;
    bus.noc2_data_in  = f;
    forever begin
      @(negedge clk);
      if (bus.noc2_ready_out) break;
      waited++;
      if (waited > 50) begin
        checks++;
        errors++;
        $error("FAIL flit_accept_timeout: observed=no_accept expected=accept");
        break;
      end
    end
    @(posedge clk);
    #1;
    bus.noc2_valid_in = 1'b0;
  endtask

  // pat: 0 random payload, 1 alternating AAAA/5555, 2 counting 1,2,3...
  task automatic do_msg(input logic [13:0] hc, input logic [7:0] hx, input logic [7:0] hy,
                        input logic [7:0] len, input logic [7:0] typ, input logic [7:0] mshr,
                        input int pat, input int hold, input int gaps);
    logic [63:0]   hdr;
    logic [63:0]   pay[$];
    logic [63:0]   p;
    logic [DW-1:0] exp_data;
    logic          exp_mis, exp_trunc;
    int            w, wsum, n;
    n   = int'(len);
    hdr = {hc, hx, hy, 4'($urandom), len, typ, mshr, 6'($urandom)};
    exp_data = '0;
    for (int i = 0; i < n; i++) begin
      if (pat == 1)      p = (i % 2 == 0) ? 64'hAAAA_AAAA_AAAA_AAAA : 64'h5555_5555_5555_5555;
      else if (pat == 2) p = 64'(i + 1);
      else               p = {$urandom, $urandom};
      pay.push_back(p);
      if (i < MAX_DATA) exp_data[64*i +: 64] = p;
    end
    exp_mis   = (hc != chipid) || (hx != coreid_x) || (hy != coreid_y);
    exp_trunc = n > MAX_DATA;
    wsum = 0;
    for (int i = 0; i <= n; i++) begin
      if (gaps > 0) repeat ($urandom_range(gaps, 0)) begin @(posedge clk); #1; end
      if (i == n) chk("valid_before_last", bus.msg_valid, 1'b0);
      if (i == 0) send_flit(hdr, w);
      else        send_flit(pay[i-1], w);
      wsum += w;
    end
    chk("valid_after_last", bus.msg_valid, 1'b1);
    if (gaps == 0) chk("flit_rate_stalls", wsum, 0);
    chk("msg_type", bus.msg_type, typ);
    chk("msg_mshrid", bus.msg_mshrid, mshr);
    chk("msg_len", bus.msg_len, len);
    chk("msg_data", bus.msg_data, exp_data);
    chk("msg_misroute", bus.msg_misroute, exp_mis);
    chk("msg_trunc", bus.msg_trunc, exp_trunc);
    bus.msg_ready = 1'b0;
    for (int c = 0; c < hold; c++) begin
      bus.noc2_valid_in = 1'b1;
      bus.noc2_data_in  = {$urandom, $urandom};
      @(negedge clk);
      chk("hold_ready_low", bus.noc2_ready_out, 1'b0);
      chk("hold_valid", bus.msg_valid, 1'b1);
      chk("hold_data", bus.msg_data, exp_data);
      chk("hold_type", bus.msg_type, typ);
      @(posedge clk);
      #1;
    end
    bus.noc2_valid_in = 1'b0;
    bus.msg_ready     = 1'b1;
    @(negedge clk);
    chk("valid_at_accept", bus.msg_valid, 1'b1);
    @(posedge clk);
    #1;
    bus.msg_ready = 1'b0;
    model_count++;
    chk("msg_count", bus.msg_count, CNT_W'(model_count));
    chk("valid_cleared", bus.msg_valid, 1'b0);
    chk("ready_after_accept", bus.noc2_ready_out, 1'b1);
  endtask

  initial begin
    int w, acc, cyc, n;
    logic [7:0] rx;
    bus.noc2_valid_in = 1'b0;
    bus.noc2_data_in  = '0;
    bus.msg_ready     = 1'b0;
    chipid = '0; coreid_x = '0; coreid_y = '0;

    #1 rst_n = 1'b0;
    #3;
    chk("rst_ready", bus.noc2_ready_out, 1'b0);
    chk("rst_valid", bus.msg_valid, 1'b0);
    chk("rst_count", bus.msg_count, '0);
    chk("rst_data", bus.msg_data, '0);
    chk("rst_type", bus.msg_type, '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1 chk("post_rst_ready", bus.noc2_ready_out, 1'b1);
    @(posedge clk); #1;

    do_msg(14'd0, 8'd0, 8'd0, 8'd2, 8'h08, 8'h05, 1, 0, 0);
    do_msg(14'd0, 8'd0, 8'd0, 8'd0, 8'h0A, 8'h11, 0, 0, 0);
    do_msg(14'd0, 8'd0, 8'd0, 8'd4, 8'h0C, 8'h22, 2, 0, 0);
    do_msg(14'd0, 8'd0, 8'd0, 8'd1, 8'h0D, 8'h33, 0, 10, 0);
    do_msg(14'd0, 8'd3, 8'd0, 8'd2, 8'h0E, 8'h44, 0, 0, 0);

    // Reset in the middle of a train: header plus one of two data flits
    send_flit({14'd0, 8'd3, 8'd0, 4'd0, 8'd2, 8'h11, 8'h22, 6'd0}, w);
    send_flit(64'hDEAD_BEEF_0123_4567, w);
    rst_n = 1'b0;
    #2;
    chk("midrst_ready", bus.noc2_ready_out, 1'b0);
    chk("midrst_valid", bus.msg_valid, 1'b0);
    chk("midrst_count", bus.msg_count, '0);
    chk("midrst_data", bus.msg_data, '0);
    chk("midrst_misroute", bus.msg_misroute, 1'b0);
    chk("midrst_len", bus.msg_len, '0);
    model_count = 0;
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("midrst_release_ready", bus.noc2_ready_out, 1'b1);
    @(posedge clk); #1;
    do_msg(14'd0, 8'd0, 8'd0, 8'd2, 8'h5A, 8'h66, 0, 0, 0);

    // Random trains with random own ids, gaps and consumer stalls
    for (int k = 0; k < 25; k++) begin
      chipid   = 14'($urandom);
      coreid_x = 8'($urandom);
      coreid_y = 8'($urandom);
      rx = ($urandom_range(1, 0) == 1) ? coreid_x : 8'($urandom);
      do_msg(($urandom_range(3, 0) == 0) ? 14'($urandom) : chipid, rx, coreid_y,
             8'($urandom_range(5, 0)), 8'($urandom), 8'($urandom), 0,
             int'($urandom_range(3, 0)), ($urandom_range(1, 0) == 1) ? 2 : 0);
    end

    // Zero-length burst up to the counter wrap point
    n   = (1 << CNT_W) - (model_count % (1 << CNT_W));
    acc = 0;
    cyc = 0;
    bus.noc2_data_in  = {14'd0, 8'd0, 8'd0, 4'd0, 8'd0, 8'h0A, 8'h01, 6'd0};
    bus.noc2_valid_in = 1'b1;
    bus.msg_ready     = 1'b1;
    while (acc < n && cyc < 4 * n + 100) begin
      @(negedge clk);
      cyc++;
      if (bus.msg_valid && bus.msg_ready) begin
        acc++;
        if (acc == n) bus.noc2_valid_in = 1'b0;
      end
    end
    @(posedge clk); #1;
    bus.msg_ready = 1'b0;
    bus.noc2_valid_in = 1'b0;
    model_count += acc;
    chk("burst_accepts", acc, n);
    chk("burst_cycles", cyc, 2 * n);
    chk("count_wrap", bus.msg_count, CNT_W'(model_count));
    chk("count_wrap_zero", bus.msg_count, '0);
    chipid = '0; coreid_x = '0; coreid_y = '0;
    do_msg(14'd0, 8'd0, 8'd0, 8'd3, 8'h42, 8'h24, 0, 1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
